// File: rtl/math_ctl_pkg.sv
// Shared definitions for the math engine control block: register offsets,
// field bit positions and the controller state encoding.
package math_ctl_pkg;

    // Register word offsets
    localparam int unsigned REG_CTRL   = 0;
    localparam int unsigned REG_SEL    = 1;
    localparam int unsigned REG_DIM    = 2;
    localparam int unsigned REG_STATUS = 3;
    localparam int unsigned REG_SCALAR = 4;
    localparam int unsigned REG_IRQEN  = 5;

    // CTRL fields
    localparam int unsigned CTRL_OP_LSB = 0;
    localparam int unsigned CTRL_GO_BIT = 31;

    // SEL fields (4 bits each)
    localparam int unsigned SEL_A_LSB = 0;
    localparam int unsigned SEL_B_LSB = 4;
    localparam int unsigned SEL_C_LSB = 8;

    // DIM fields (16 bits each)
    localparam int unsigned DIM_M_LSB = 0;
    localparam int unsigned DIM_N_LSB = 16;

    // STATUS bits
    localparam int unsigned ST_BUSY_BIT = 0;
    localparam int unsigned ST_DONE_BIT = 1;
    localparam int unsigned ST_ERR_BIT  = 2;
    localparam int unsigned ST_OVR_BIT  = 3;

    // IRQEN bits
    localparam int unsigned IRQEN_DONE_BIT = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RUN  = 2'd2
    } math_state_t;

endpackage

// File: rtl/math_ctl_if.sv
// Bridge-side register bus plus math engine handshake and operand fields.
interface math_ctl_if #(
    parameter int BRAM_AW = 12,
    parameter int DW      = 32
);
    logic               bram_en;
    logic               bram_we;
    logic [BRAM_AW-1:0] bram_a;
    logic [DW-1:0]      bram_di;
    logic [DW-1:0]      bram_do;

    logic               math_req;
    logic               math_ack;
    logic               math_done;
    logic               math_err;
    logic [3:0]         math_op;
    logic [3:0]         math_a_sel;
    logic [3:0]         math_b_sel;
    logic [3:0]         math_c_sel;
    logic [15:0]        math_m;
    logic [15:0]        math_n;
    logic [DW-1:0]      math_scalar;
    logic               irq;

    // Controller view
    modport slave (
        input  bram_en, bram_we, bram_a, bram_di,
        output bram_do,
        output math_req, math_op, math_a_sel, math_b_sel, math_c_sel,
        output math_m, math_n, math_scalar, irq,
        input  math_ack, math_done, math_err
    );

    // Bridge / engine view
    modport master (
        output bram_en, bram_we, bram_a, bram_di,
        input  bram_do,
        input  math_req, math_op, math_a_sel, math_b_sel, math_c_sel,
        input  math_m, math_n, math_scalar, irq,
        output math_ack, math_done, math_err
    );
endinterface

// File: rtl/math_ctl_fsm.sv
// Request/run sequencer: raises math_req until the engine accepts, then
// waits for the completion pulse and reports it to the register file.
module math_ctl_fsm
    import math_ctl_pkg::*;
(
    input  logic fmc_clk,
    input  logic rst_n,
    input  logic start,
    input  logic math_ack,
    input  logic math_done,
    input  logic math_err,
    output logic busy,
    output logic math_req,
    output logic done_set,
    output logic err_set
);

    math_state_t state_q, state_d;

    // State register
    always_ff @(posedge fmc_clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and completion strobes; done is only honoured in RUN
    always_comb begin
        state_d  = state_q;
        done_set = 1'b0;
        err_set  = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = REQ;
            REQ:  if (math_ack) state_d = RUN;
            RUN: begin
                if (math_done) begin
                    state_d  = IDLE;
                    done_set = 1'b1;
                    err_set  = math_err;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign math_req = (state_q == REQ);
    assign busy     = (state_q != IDLE);

endmodule

// File: rtl/math_ctl.sv
// Register file, read mux and interrupt for the math engine controller.
module math_ctl
    import math_ctl_pkg::*;
#(
    parameter int BRAM_AW  = 12,
    parameter int DW       = 32,
    parameter int CTL_REGS = 6
) (
    input logic       fmc_clk,
    input logic       rst_n,
    math_ctl_if.slave bus
);

    logic [BRAM_AW-1:0] addr;
    logic [DW-1:0]      di;
    logic               wr_hit, rd_hit;
    logic               wr_ctrl, wr_sel, wr_dim, wr_status, wr_scalar, wr_irqen;
    logic               busy, start, done_set, err_set, cfg_blocked;

    logic [3:0]    op_q, a_q, b_q, c_q;
    logic [15:0]   m_q, n_q;
    logic [DW-1:0] scalar_q;
    logic          done_q, err_q, ovr_q, irqen_q, irq_q;
    logic [DW-1:0] rd_data, do_q;

    logic unused_di;
    assign unused_di = ^di;

    assign addr   = bus.bram_a;
    assign di     = bus.bram_di;
    assign rd_hit = addr < BRAM_AW'(CTL_REGS);
    assign wr_hit = bus.bram_en && bus.bram_we && rd_hit;

    assign wr_ctrl   = wr_hit && (addr == BRAM_AW'(REG_CTRL));
    assign wr_sel    = wr_hit && (addr == BRAM_AW'(REG_SEL));
    assign wr_dim    = wr_hit && (addr == BRAM_AW'(REG_DIM));
    assign wr_status = wr_hit && (addr == BRAM_AW'(REG_STATUS));
    assign wr_scalar = wr_hit && (addr == BRAM_AW'(REG_SCALAR));
    assign wr_irqen  = wr_hit && (addr == BRAM_AW'(REG_IRQEN));

    assign cfg_blocked = busy && (wr_ctrl || wr_sel || wr_dim || wr_scalar);
    assign start       = wr_ctrl && !busy && di[CTRL_GO_BIT];

    math_ctl_fsm u_fsm (
        .fmc_clk   (fmc_clk),
        .rst_n     (rst_n),
        .start     (start),
        .math_ack  (bus.math_ack),
        .math_done (bus.math_done),
        .math_err  (bus.math_err),
        .busy      (busy),
        .math_req  (bus.math_req),
        .done_set  (done_set),
        .err_set   (err_set)
    );

    // Configuration and sticky status registers; hardware set beats W1C clear
    always_ff @(posedge fmc_clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            m_q      <= '0;
            n_q      <= '0;
            scalar_q <= '0;
            irqen_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            if (wr_ctrl && !busy) op_q <= di[CTRL_OP_LSB +: 4];
            if (wr_sel && !busy) begin
                a_q <= di[SEL_A_LSB +: 4];
                b_q <= di[SEL_B_LSB +: 4];
                c_q <= di[SEL_C_LSB +: 4];
            end
            if (wr_dim && !busy) begin
                m_q <= di[DIM_M_LSB +: 16];
                n_q <= di[DIM_N_LSB +: 16];
            end
            if (wr_scalar && !busy) scalar_q <= di;
            if (wr_irqen) irqen_q <= di[IRQEN_DONE_BIT];

            if (done_set)                          done_q <= 1'b1;
            else if (wr_status && di[ST_DONE_BIT]) done_q <= 1'b0;
            if (err_set)                           err_q <= 1'b1;
            else if (wr_status && di[ST_ERR_BIT])  err_q <= 1'b0;
            if (cfg_blocked)                       ovr_q <= 1'b1;
            else if (wr_status && di[ST_OVR_BIT])  ovr_q <= 1'b0;
        end
    end

    // Read mux; go and unused bits read back as zero
    always_comb begin
        rd_data = '0;
        if (rd_hit) begin
            case (addr)
                BRAM_AW'(REG_CTRL):   rd_data = DW'(op_q);
                BRAM_AW'(REG_SEL):    rd_data = DW'({c_q, b_q, a_q});
                BRAM_AW'(REG_DIM):    rd_data = DW'({n_q, m_q});
                BRAM_AW'(REG_STATUS): rd_data = DW'({ovr_q, err_q, done_q, busy});
                BRAM_AW'(REG_SCALAR): rd_data = scalar_q;
                BRAM_AW'(REG_IRQEN):  rd_data = DW'(irqen_q);
                default:              rd_data = '0;
            endcase
        end
    end

    // Registered read data and interrupt
    always_ff @(posedge fmc_clk or negedge rst_n) begin
        if (!rst_n) begin
            do_q  <= '0;
            irq_q <= 1'b0;
        end else begin
            if (bus.bram_en) do_q <= rd_data;
            irq_q <= done_q & irqen_q;
        end
    end

    assign bus.bram_do     = do_q;
    assign bus.irq         = irq_q;
    assign bus.math_op     = op_q;
    assign bus.math_a_sel  = a_q;
    assign bus.math_b_sel  = b_q;
    assign bus.math_c_sel  = c_q;
    assign bus.math_m      = m_q;
    assign bus.math_n      = n_q;
    assign bus.math_scalar = scalar_q;

endmodule

// File: tb/tb_math_ctl.sv
// Self-checking bench for math_ctl: directed corner sequences, a vector
// table and randomized traffic against a register-level reference model.
module tb_math_ctl;
    import math_ctl_pkg::*;

    logic fmc_clk = 1'b0;
    logic rst_n   = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    always #5 fmc_clk = ~fmc_clk;

    math_ctl_if #(.BRAM_AW(12), .DW(32)) bus ();

    math_ctl #(.BRAM_AW(12), .DW(32), .CTL_REGS(6)) dut (
        .fmc_clk (fmc_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    // Reference model: architectural register contents and engine phase
    // (0 = idle, 1 = awaiting accept, 2 = running)
    logic [3:0]  m_op;
    logic [11:0] m_sel;
    logic [31:0] m_dim, m_scalar;
    logic        m_done, m_err, m_ovr, m_irqen;
    int          m_phase;

    task automatic m_reset();
        m_op = '0; m_sel = '0; m_dim = '0; m_scalar = '0;
        m_done = 1'b0; m_err = 1'b0; m_ovr = 1'b0; m_irqen = 1'b0;
        m_phase = 0;
    endtask

    task automatic m_write(input logic [11:0] a, input logic [31:0] d);
        bit cfg;
        if (a >= 12'd6) return;
        cfg = (a == 12'd0) || (a == 12'd1) || (a == 12'd2) || (a == 12'd4);
        if (cfg && m_phase != 0) begin
            m_ovr = 1'b1;
            return;
        end
        case (a)
            12'd0: begin m_op = d[3:0]; if (d[31]) m_phase = 1; end
            12'd1: m_sel = d[11:0];
            12'd2: m_dim = d;
            12'd3: begin
                if (d[1]) m_done = 1'b0;
                if (d[2]) m_err  = 1'b0;
                if (d[3]) m_ovr  = 1'b0;
            end
            12'd4: m_scalar = d;
            default: m_irqen = d[0];
        endcase
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'd0: return {28'd0, m_op};
            12'd1: return {20'd0, m_sel};
            12'd2: return m_dim;
            12'd3: return {28'd0, m_ovr, m_err, m_done, (m_phase != 0)};
            12'd4: return m_scalar;
            12'd5: return {31'd0, m_irqen};
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        bus.bram_en = 1'b1; bus.bram_we = 1'b1; bus.bram_a = a; bus.bram_di = d;
        @(posedge fmc_clk); #1;
        bus.bram_en = 1'b0; bus.bram_we = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d);
        bus.bram_en = 1'b1; bus.bram_we = 1'b0; bus.bram_a = a;
        @(posedge fmc_clk); #1;
        bus.bram_en = 1'b0;
        d = bus.bram_do;
    endtask

    task automatic pulse_ack();
        bus.math_ack = 1'b1;
        @(posedge fmc_clk); #1;
        bus.math_ack = 1'b0;
    endtask

    task automatic pulse_done(input logic e);
        bus.math_done = 1'b1; bus.math_err = e;
        @(posedge fmc_clk); #1;
        bus.math_done = 1'b0; bus.math_err = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        chk(name, d, exp);
    endtask

    typedef struct {
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] rexp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [31:0] d;
        bus.bram_en = 1'b0; bus.bram_we = 1'b0; bus.bram_a = '0; bus.bram_di = '0;
        bus.math_ack = 1'b0; bus.math_done = 1'b0; bus.math_err = 1'b0;

        vecs[0] = '{REG_SEL,    32'hFFFF_FFFF, 32'h0000_0FFF};
        vecs[1] = '{REG_DIM,    32'h1234_5678, 32'h1234_5678};
        vecs[2] = '{REG_CTRL,   32'h7FFF_FFF5, 32'h0000_0005};
        vecs[3] = '{REG_SCALAR, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[4] = '{REG_IRQEN,  32'hFFFF_FFFE, 32'h0000_0000};
        vecs[5] = '{REG_IRQEN,  32'h0000_0001, 32'h0000_0001};
        vecs[6] = '{REG_STATUS, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[7] = '{12'd6,      32'hFFFF_FFFF, 32'h0000_0000};
        vecs[8] = '{12'hFFF,    32'hFFFF_FFFF, 32'h0000_0000};
        vecs[9] = '{12'd7,      32'hA5A5_A5A5, 32'h0000_0000};

        // Reset state
        repeat (3) @(posedge fmc_clk);
        #1;
        chk("rst_bram_do", bus.bram_do, 32'd0);
        chk("rst_req", {31'd0, bus.math_req}, 32'd0);
        chk("rst_irq", {31'd0, bus.irq}, 32'd0);
        rst_n = 1'b1;
        @(posedge fmc_clk); #1;
        for (int unsigned i = 0; i < 6; i++) rd_chk("rst_reg", 12'(i), 32'd0);

        // Launch an operation
        wr(REG_SEL, 32'h0000_0321);
        wr(REG_DIM, 32'h0008_0004);
        wr(REG_CTRL, 32'h8000_0002);
        chk("go_req", {31'd0, bus.math_req}, 32'd1);
        chk("go_fields", {bus.math_op, bus.math_a_sel, bus.math_b_sel, bus.math_c_sel},
            32'h0000_2123);
        chk("go_dim", {bus.math_n, bus.math_m}, 32'h0008_0004);

        // Request held until accepted
        for (int unsigned i = 0; i < 5; i++) begin
            rd_chk("req_status", REG_STATUS, 32'h1);
            chk("req_hold", {31'd0, bus.math_req}, 32'd1);
        end
        pulse_ack();
        chk("req_drop", {31'd0, bus.math_req}, 32'd0);
        rd_chk("run_status", REG_STATUS, 32'h1);

        // Writes while busy
        wr(REG_DIM, 32'h1111_2222);
        rd_chk("busy_dim", REG_DIM, 32'h0008_0004);
        rd_chk("busy_ovr", REG_STATUS, 32'h9);
        wr(REG_CTRL, 32'h8000_0005);
        chk("busy_go_req", {31'd0, bus.math_req}, 32'd0);
        chk("busy_go_op", {28'd0, bus.math_op}, 32'd2);

        // Completion with error and interrupt
        wr(REG_IRQEN, 32'h1);
        wr(REG_STATUS, 32'h8);
        rd_chk("ovr_clr", REG_STATUS, 32'h1);
        pulse_done(1'b1);
        rd_chk("done_status", REG_STATUS, 32'h6);
        chk("done_irq", {31'd0, bus.irq}, 32'd1);
        wr(REG_STATUS, 32'h6);
        rd_chk("w1c_status", REG_STATUS, 32'h0);
        chk("w1c_irq", {31'd0, bus.irq}, 32'd0);

        // Hardware set and W1C clear in the same cycle
        wr(REG_CTRL, 32'h8000_0002);
        pulse_ack();
        bus.bram_en = 1'b1; bus.bram_we = 1'b1; bus.bram_a = REG_STATUS; bus.bram_di = 32'h6;
        bus.math_done = 1'b1; bus.math_err = 1'b1;
        @(posedge fmc_clk); #1;
        bus.bram_en = 1'b0; bus.bram_we = 1'b0; bus.math_done = 1'b0; bus.math_err = 1'b0;
        rd_chk("set_wins", REG_STATUS, 32'h6);
        wr(REG_STATUS, 32'h6);

        // Stray completion pulses
        pulse_done(1'b1);
        rd_chk("done_idle", REG_STATUS, 32'h0);
        wr(REG_CTRL, 32'h8000_0001);
        pulse_done(1'b1);
        rd_chk("done_req", REG_STATUS, 32'h1);
        chk("done_req_hold", {31'd0, bus.math_req}, 32'd1);
        pulse_ack();

        // Reset during RUN
        rst_n = 1'b0;
        #1;
        chk("mid_rst_do", bus.bram_do, 32'd0);
        chk("mid_rst_req", {31'd0, bus.math_req}, 32'd0);
        repeat (2) @(posedge fmc_clk);
        #1;
        rst_n = 1'b1;
        @(posedge fmc_clk); #1;
        rd_chk("post_rst_status", REG_STATUS, 32'h0);
        pulse_done(1'b0);
        rd_chk("post_rst_done", REG_STATUS, 32'h0);
        rd_chk("post_rst_sel", REG_SEL, 32'h0);
        chk("post_rst_req", {31'd0, bus.math_req}, 32'd0);

        // Vector table
        m_reset();
        foreach (vecs[i]) begin
            wr(vecs[i].addr, vecs[i].wdata);
            m_write(vecs[i].addr, vecs[i].wdata);
            rd_chk("vec", vecs[i].addr, vecs[i].rexp);
        end
        for (int unsigned i = 0; i < 6; i++) rd_chk("vec_regs", 12'(i), m_read(12'(i)));

        // Randomized traffic
        for (int unsigned step = 0; step < 400; step++) begin
            int unsigned kind;
            logic [11:0] a;
            logic [31:0] wd;
            logic        e;
            kind = $urandom_range(0, 9);
            a = ($urandom_range(0, 9) < 8) ? 12'($urandom_range(0, 7)) : 12'($urandom_range(8, 4095));
            if (kind <= 3) begin
                wd = $urandom;
                wr(a, wd);
                m_write(a, wd);
            end else if (kind <= 6) begin
                rd(a, d);
                chk("rand_rd", d, m_read(a));
                chk("rand_irq", {31'd0, bus.irq}, {31'd0, m_done & m_irqen});
            end else if (kind == 7) begin
                pulse_ack();
                if (m_phase == 1) m_phase = 2;
            end else if (kind == 8) begin
                e = 1'($urandom_range(0, 1));
                pulse_done(e);
                if (m_phase == 2) begin
                    m_phase = 0;
                    m_done  = 1'b1;
                    if (e) m_err = 1'b1;
                end
            end else begin
                @(posedge fmc_clk); #1;
            end
            chk("rand_req", {31'd0, bus.math_req}, {31'd0, m_phase == 1});
            chk("rand_op_sel", {bus.math_op, bus.math_c_sel, bus.math_b_sel, bus.math_a_sel},
                {16'd0, m_op, m_sel});
            chk("rand_dim", {bus.math_n, bus.math_m}, m_dim);
            chk("rand_scalar", bus.math_scalar, m_scalar);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/math_ctl.md
MATH_CTL -- requirements
Module: math_ctl

Interface
REQ-001 Parameters SHALL be: BRAM_AW, default 12, control-port address width; DW, default 32, data width; CTL_REGS, default 6, number of implemented registers.
REQ-002 fmc_clk  in  1  sole clock; every port SHALL be synchronous to it.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 bram_en  in  1  control-line select (bram_en[BRAMS-1] of the FMC bridge).
REQ-005 bram_we  in  1  write strobe, qualified by bram_en.
REQ-006 bram_a  in  BRAM_AW  word address.
REQ-007 bram_di  in  DW  write data from the FMC bridge.
REQ-008 bram_do  out  DW  read data to the FMC bridge.
REQ-009 math_req  out  1  operation request to the math engine.
REQ-010 math_ack  in  1  engine accepted the request.
REQ-011 math_done  in  1  one-cycle completion pulse.
REQ-012 math_err  in  1  error flag, sampled with math_done.
REQ-013 math_op  out  4  opcode.
REQ-014 math_a_sel, math_b_sel, math_c_sel  out  4 each  operand and result BRAM indices.
REQ-015 math_m, math_n  out  16 each  matrix dimensions.
REQ-016 math_scalar  out  DW  scalar operand.
REQ-017 irq  out  1  completion interrupt, level.

Function
REQ-018 Register map SHALL be:
- 0 CTRL: [3:0] op, [31] go (write-only, self-clearing).
- 1 SEL: [3:0] a, [7:4] b, [11:8] c.
- 2 DIM: [15:0] m, [31:16] n.
- 3 STATUS: [0] busy (RO), [1] done (W1C), [2] err (W1C), [3] ovr (W1C).
- 4 SCALAR.
- 5 IRQEN: [0] enables done-interrupt.
REQ-019 A write SHALL occur when bram_en && bram_we && bram_a < CTL_REGS; addresses >= CTL_REGS SHALL be ignored.
REQ-020 bram_do SHALL be registered with 1-cycle latency after bram_en, and SHALL read 0 for unimplemented addresses and unused bits.
REQ-021 math_op, math_*_sel, math_m, math_n and math_scalar SHALL be driven directly from register fields.
REQ-022 The FSM states SHALL be IDLE, REQ and RUN.
- IDLE -> REQ on a CTRL write with go=1.
- REQ holds math_req=1 until math_ack=1, then -> RUN; math_req SHALL drop the cycle after ack.
- RUN -> IDLE on math_done; set done, and set err if math_err=1.
REQ-023 busy SHALL be 1 in REQ and RUN.
REQ-024 Writes to CTRL, SEL, DIM and SCALAR while busy SHALL be ignored and SHALL set ovr.
REQ-025 A go while busy SHALL NOT restart the engine.
REQ-026 When a W1C write and hardware set of done or err land in the same cycle, set SHALL win.
REQ-027 math_done in IDLE or REQ SHALL be ignored.
REQ-028 A STATUS write SHALL leave busy unaffected.
REQ-029 irq SHALL equal done & IRQEN[0], registered.

Reset
REQ-030 Asserting rst_n low SHALL clear all registers, bram_do, math_req and irq to 0 and force IDLE, including mid-operation; a math_done arriving after reset SHALL be ignored.

Structure
REQ-031 Register offsets, field bit positions and the FSM state encoding SHALL reside in a shared package, math_ctl_pkg.
REQ-032 The FSM SHALL be a sub-module, math_ctl_fsm; the register file and read mux SHALL stay in math_ctl.

Verification
REQ-033 Write SEL=0x321, DIM=0x00080004, then CTRL=0x80000002 -> math_req=1 next cycle; math_op=2, a=1, b=2, c=3, m=4, n=8.
REQ-034 Hold math_ack=0 for 5 cycles, then pulse it -> math_req stays high until ack, drops next cycle; STATUS reads 0x1 throughout.
REQ-035 Pulse math_done with math_err=1 and IRQEN=1 -> STATUS=0x6 and irq=1; write STATUS=0x6 -> STATUS=0, irq=0.
REQ-036 Write DIM while busy -> DIM unchanged, ovr=1; write go while busy -> no second math_req.
REQ-037 Read address 6 and 0xFFF -> bram_do=0; a write to address 6 changes no register.
REQ-038 Assert rst_n low in RUN -> math_req=0, STATUS=0, IDLE; a subsequent math_done leaves done=0.
